// File: rtl/pyrm_decode_branch_pkg.sv
// Shared RV64 decode constants, FSM state encoding and small decode helpers
// for the decode/branch-resolve slice.
package pyrm_decode_branch_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned QDEPTH = 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDREG  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_BRSEND = 2'd3
  } state_e;

  // Opcodes whose next PC this block must resolve; JAL stays with fetch.
  function automatic logic is_resolve_op(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/pyrm_decode_branch_if.sv
// Bundle of the fetch, branch-redirect, register-file and downstream channels
// seen by the decode/branch-resolve block.
interface pyrm_decode_branch_if #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32
);
  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  logic [PC_W-1:0]   pc_pyri;
  logic              pc_valid_pyri;
  logic              pc_retry_pyro;
  logic [INST_W-1:0] inst_pyri;
  logic              inst_valid_pyri;
  logic              inst_retry_pyro;

  logic [PC_W-1:0]   branch_pc_pyro;
  logic              branch_pc_valid_pyro;
  logic              branch_pc_retry_pyri;

  logic [REG_AW-1:0] rs1_addr_pyro;
  logic [REG_AW-1:0] rs2_addr_pyro;
  logic [XLEN-1:0]   rs1_data_pyri;
  logic [XLEN-1:0]   rs2_data_pyri;

  logic [PC_W-1:0]   dec_pc_pyro;
  logic [INST_W-1:0] dec_inst_pyro;
  logic              dec_valid_pyro;
  logic              dec_retry_pyri;

  // Decoder side
  modport slave (
    input  pc_pyri, pc_valid_pyri, inst_pyri, inst_valid_pyri,
    output pc_retry_pyro, inst_retry_pyro,
    output branch_pc_pyro, branch_pc_valid_pyro,
    input  branch_pc_retry_pyri,
    output rs1_addr_pyro, rs2_addr_pyro,
    input  rs1_data_pyri, rs2_data_pyri,
    output dec_pc_pyro, dec_inst_pyro, dec_valid_pyro,
    input  dec_retry_pyri
  );

  // Fetch / regfile / downstream side
  modport master (
    output pc_pyri, pc_valid_pyri, inst_pyri, inst_valid_pyri,
    input  pc_retry_pyro, inst_retry_pyro,
    input  branch_pc_pyro, branch_pc_valid_pyro,
    output branch_pc_retry_pyri,
    input  rs1_addr_pyro, rs2_addr_pyro,
    output rs1_data_pyri, rs2_data_pyri,
    input  dec_pc_pyro, dec_inst_pyro, dec_valid_pyro,
    output dec_retry_pyri
  );

endinterface

// File: rtl/pyrm_branch_target.sv
// Combinational next-PC resolution for BRANCH and JALR: immediate extraction,
// branch comparator and target adders (all modulo 2^PC_W).
module pyrm_branch_target
  import pyrm_decode_branch_pkg::*;
#(
  parameter int unsigned PC_W = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [PC_W-1:0] target_c_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [PC_W-1:0] imm_i_sx;
  logic [PC_W-1:0] imm_b_sx;
  logic [PC_W-1:0] jalr_sum;
  logic            taken;
  logic            unused_reg_fields;

  assign opcode   = inst_i[6:0];
  assign funct3   = inst_i[14:12];
  assign imm_i_sx = {{(PC_W-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_b_sx = {{(PC_W-13){inst_i[31]}}, inst_i[31], inst_i[7],
                     inst_i[30:25], inst_i[11:8], 1'b0};
  assign jalr_sum = PC_W'(rs1_i) + imm_i_sx;

  // Register specifiers are consumed by the regfile read port, not here.
  assign unused_reg_fields = ^inst_i[24:15];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_i == rs2_i);
      F3_BNE:  taken = (rs1_i != rs2_i);
      F3_BLT:  taken = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken = (rs1_i <  rs2_i);
      F3_BGEU: taken = (rs1_i >= rs2_i);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target_c_o = pc_i + PC_W'(4);
    if (opcode == OP_JALR) begin
      target_c_o = {jalr_sum[PC_W-1:1], 1'b0};
    end else if (taken) begin
      target_c_o = pc_i + imm_b_sx;
    end
  end

endmodule

// File: rtl/pyrm_decode_branch.sv
// Decode-stage consumer of the fetch interface: queues pc/inst pairs for the
// downstream stage and resolves BRANCH/JALR targets back to fetch.
module pyrm_decode_branch
  import pyrm_decode_branch_pkg::*;
#(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_pyri,
  pyrm_decode_branch_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INST_W-1:0]   inst_q;
  logic [PC_W-1:0]     target_q;
  logic                bpv_q;
  logic [REG_AW-1:0]   rs1_addr_q;
  logic [REG_AW-1:0]   rs2_addr_q;

  logic [PC_W-1:0]     q_pc   [QDEPTH];
  logic [INST_W-1:0]   q_inst [QDEPTH];
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                full;
  logic                retry;
  logic                accept;
  logic                new_br;
  logic                pop;
  logic [PC_W-1:0]     target_c;

  assign full = (cnt_q == CNT_W'(QDEPTH));

  // Holding retry through BRSEND lets the target instruction land on the
  // same cycle fetch takes the redirect.
  always_comb begin
    retry = full;
    case (state_q)
      ST_RDREG, ST_EXEC: retry = 1'b1;
      ST_BRSEND:         retry = full | bus.branch_pc_retry_pyri;
      default:           retry = full;
    endcase
  end

  assign accept = bus.pc_valid_pyri & bus.inst_valid_pyri & ~retry;
  assign new_br = accept & is_resolve_op(bus.inst_pyri[6:0]);
  assign pop    = (cnt_q != '0) & ~bus.dec_retry_pyri;

  pyrm_branch_target #(
    .PC_W (PC_W),
    .XLEN (XLEN)
  ) u_target (
    .pc_i       (pc_q),
    .inst_i     (inst_q[31:0]),
    .rs1_i      (bus.rs1_data_pyri),
    .rs2_i      (bus.rs2_data_pyri),
    .target_c_o (target_c)
  );

  always_ff @(posedge clk) begin
    if (reset_pyri) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      inst_q     <= '0;
      target_q   <= '0;
      bpv_q      <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      if (accept) begin
        pc_q   <= bus.pc_pyri;
        inst_q <= bus.inst_pyri;
      end
      // Addresses are valid only during the RDREG cycle that follows
      if (new_br) begin
        rs1_addr_q <= bus.inst_pyri[19:15];
        rs2_addr_q <= bus.inst_pyri[24:20];
      end

      case (state_q)
        ST_IDLE: begin
          if (new_br) state_q <= ST_RDREG;
        end
        ST_RDREG: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          target_q <= target_c;
          bpv_q    <= 1'b1;
          state_q  <= ST_BRSEND;
        end
        ST_BRSEND: begin
          if (!bus.branch_pc_retry_pyri) begin
            bpv_q   <= 1'b0;
            state_q <= new_br ? ST_RDREG : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Queue storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_pc[wr_ptr_q]   <= bus.pc_pyri;
      q_inst[wr_ptr_q] <= bus.inst_pyri;
    end
  end

  assign bus.pc_retry_pyro        = retry;
  assign bus.inst_retry_pyro      = retry;
  assign bus.branch_pc_pyro       = target_q;
  assign bus.branch_pc_valid_pyro = bpv_q;
  assign bus.rs1_addr_pyro        = rs1_addr_q;
  assign bus.rs2_addr_pyro        = rs2_addr_q;
  assign bus.dec_pc_pyro          = q_pc[rd_ptr_q];
  assign bus.dec_inst_pyro        = q_inst[rd_ptr_q];
  assign bus.dec_valid_pyro       = (cnt_q != '0);

endmodule

// File: tb/tb_pyrm_decode_branch.sv
// Directed bench for pyrm_decode_branch: fetch handshake, queue ordering,
// branch/JALR target resolution, redirect back-pressure and mid-flight reset.
module tb_pyrm_decode_branch;

  logic clk;
  logic reset;
  logic [63:0] regs [32];
  int n_checks;
  int n_fail;

  pyrm_decode_branch_if #(.PC_W(64), .INST_W(32)) bus ();

  pyrm_decode_branch #(.PC_W(64), .INST_W(32), .QDEPTH(2)) dut (
    .clk        (clk),
    .reset_pyri (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Register file: data returns one cycle after the address
  always @(posedge clk) begin
    bus.rs1_data_pyri <= regs[bus.rs1_addr_pyro];
    bus.rs2_data_pyri <= regs[bus.rs2_addr_pyro];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // Present one pair, expect it taken on the next edge, then withdraw it
  task automatic send(input string tag, input logic [63:0] pc, input logic [31:0] inst);
    bus.pc_pyri         = pc;
    bus.inst_pyri       = inst;
    bus.pc_valid_pyri   = 1'b1;
    bus.inst_valid_pyri = 1'b1;
    #1;
    check_eq({tag, "_acc_retry"}, bus.pc_retry_pyro, 1'b0);
    tick();
    bus.pc_valid_pyri   = 1'b0;
    bus.inst_valid_pyri = 1'b0;
  endtask

  task automatic run_branch(input string tag, input logic [63:0] pc, input logic [31:0] inst,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] exp_tgt);
    send(tag, pc, inst);
    check_eq({tag, "_rs1a"}, bus.rs1_addr_pyro, rs1);
    check_eq({tag, "_rs2a"}, bus.rs2_addr_pyro, rs2);
    check_eq({tag, "_retry_t1"}, bus.inst_retry_pyro, 1'b1);
    tick();
    check_eq({tag, "_retry_t2"}, bus.pc_retry_pyro, 1'b1);
    check_eq({tag, "_bpv_t2"}, bus.branch_pc_valid_pyro, 1'b0);
    check_eq({tag, "_rsa_t2"}, bus.rs1_addr_pyro, 5'd0);
    tick();
    check_eq({tag, "_bpv_t3"}, bus.branch_pc_valid_pyro, 1'b1);
    check_eq({tag, "_target"}, bus.branch_pc_pyro, exp_tgt);
    check_eq({tag, "_retry_t3"}, bus.pc_retry_pyro, 1'b0);
    tick();
    check_eq({tag, "_bpv_done"}, bus.branch_pc_valid_pyro, 1'b0);
  endtask

  initial begin
    logic [31:0] ins_a;
    logic [31:0] ins_b;
    logic [31:0] ins_c;
    clk = 1'b0;
    reset = 1'b1;
    n_checks = 0;
    n_fail = 0;
    bus.pc_pyri = '0;
    bus.inst_pyri = '0;
    bus.pc_valid_pyri = 1'b0;
    bus.inst_valid_pyri = 1'b0;
    bus.branch_pc_retry_pyri = 1'b0;
    bus.dec_retry_pyri = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 64'(i);
    regs[1] = 64'd5;
    regs[2] = 64'd5;
    regs[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    regs[4] = 64'd1;
    regs[5] = 64'h8000_1003;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_dec_valid", bus.dec_valid_pyro, 1'b0);
    check_eq("rst_bpv", bus.branch_pc_valid_pyro, 1'b0);
    check_eq("rst_target", bus.branch_pc_pyro, 64'h0);
    check_eq("rst_retry", bus.pc_retry_pyro, 1'b0);
    check_eq("rst_rs1a", bus.rs1_addr_pyro, 5'd0);

    // Plain ALU op passes straight through the queue
    ins_a = enc_addi(5'd1, 5'd0, 12'd7);
    send("addi", 64'h8000_0000, ins_a);
    check_eq("addi_dec_valid", bus.dec_valid_pyro, 1'b1);
    check_eq("addi_dec_pc", bus.dec_pc_pyro, 64'h8000_0000);
    check_eq("addi_dec_inst", bus.dec_inst_pyro, ins_a);
    check_eq("addi_bpv", bus.branch_pc_valid_pyro, 1'b0);
    check_eq("addi_retry", bus.pc_retry_pyro, 1'b0);
    tick();
    check_eq("addi_popped", bus.dec_valid_pyro, 1'b0);

    run_branch("beq",  64'h8000_0010, enc_b(3'b000, 5'd1, 5'd2, 13'd16), 5'd1, 5'd2, 64'h8000_0020);
    run_branch("bne",  64'h8000_0030, enc_b(3'b001, 5'd1, 5'd2, 13'd16), 5'd1, 5'd2, 64'h8000_0034);
    run_branch("blt",  64'h8000_0100, enc_b(3'b100, 5'd3, 5'd4, 13'd32), 5'd3, 5'd4, 64'h8000_0120);
    run_branch("bltu", 64'h8000_0200, enc_b(3'b110, 5'd3, 5'd4, 13'd32), 5'd3, 5'd4, 64'h8000_0204);
    run_branch("bge",  64'h8000_0300, enc_b(3'b101, 5'd3, 5'd4, 13'd32), 5'd3, 5'd4, 64'h8000_0304);
    run_branch("bgeu", 64'h8000_0400, enc_b(3'b111, 5'd3, 5'd4, 13'h1FF8), 5'd3, 5'd4, 64'h8000_03F8);
    run_branch("f3_010", 64'h8000_0500, enc_b(3'b010, 5'd1, 5'd2, 13'd16), 5'd1, 5'd2, 64'h8000_0504);
    run_branch("beq_min", 64'h8000_2000, enc_b(3'b000, 5'd1, 5'd2, 13'h1000), 5'd1, 5'd2, 64'h8000_1000);

    // JALR with redirect back-pressure for three cycles
    bus.branch_pc_retry_pyri = 1'b1;
    ins_a = enc_addi(5'd2, 5'd2, 12'd1);
    send("jalr", 64'h8000_0600, enc_jalr(5'd1, 5'd5, 12'hFFC));
    check_eq("jalr_rs1a", bus.rs1_addr_pyro, 5'd5);
    check_eq("jalr_rs2a", bus.rs2_addr_pyro, 5'd28);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("jalr_hold_bpv", bus.branch_pc_valid_pyro, 1'b1);
      check_eq("jalr_hold_tgt", bus.branch_pc_pyro, 64'h8000_0FFE);
      bus.pc_pyri = 64'h8000_0FFE;
      bus.inst_pyri = ins_a;
      bus.pc_valid_pyri = 1'b1;
      bus.inst_valid_pyri = 1'b1;
      #1;
      check_eq("jalr_hold_retry", bus.inst_retry_pyro, 1'b1);
      tick();
    end
    bus.branch_pc_retry_pyri = 1'b0;
    #1;
    check_eq("jalr_release_retry", bus.pc_retry_pyro, 1'b0);
    tick();
    bus.pc_valid_pyri = 1'b0;
    bus.inst_valid_pyri = 1'b0;
    check_eq("jalr_bpv_drop", bus.branch_pc_valid_pyro, 1'b0);
    check_eq("jalr_tgt_dec_valid", bus.dec_valid_pyro, 1'b1);
    check_eq("jalr_tgt_dec_pc", bus.dec_pc_pyro, 64'h8000_0FFE);
    check_eq("jalr_tgt_dec_inst", bus.dec_inst_pyro, ins_a);
    tick();

    // Queue fills under downstream stall; third pair waits, order preserved
    bus.dec_retry_pyri = 1'b1;
    ins_a = enc_addi(5'd3, 5'd0, 12'd1);
    ins_b = enc_addi(5'd4, 5'd0, 12'd2);
    ins_c = enc_addi(5'd5, 5'd0, 12'd3);
    send("qa", 64'h8000_0700, ins_a);
    send("qb", 64'h8000_0704, ins_b);
    check_eq("q_full_valid", bus.dec_valid_pyro, 1'b1);
    check_eq("q_full_head", bus.dec_pc_pyro, 64'h8000_0700);
    bus.pc_pyri = 64'h8000_0708;
    bus.inst_pyri = ins_c;
    bus.pc_valid_pyri = 1'b1;
    bus.inst_valid_pyri = 1'b1;
    #1;
    check_eq("q_full_retry", bus.pc_retry_pyro, 1'b1);
    tick();
    check_eq("q_stall_head", bus.dec_pc_pyro, 64'h8000_0700);
    bus.dec_retry_pyri = 1'b0;
    #1;
    check_eq("q_full_pop_retry", bus.inst_retry_pyro, 1'b1);
    tick();
    check_eq("q_second_head", bus.dec_pc_pyro, 64'h8000_0704);
    check_eq("q_second_inst", bus.dec_inst_pyro, ins_b);
    check_eq("q_room_retry", bus.pc_retry_pyro, 1'b0);
    tick();
    bus.pc_valid_pyri = 1'b0;
    bus.inst_valid_pyri = 1'b0;
    check_eq("q_third_head", bus.dec_pc_pyro, 64'h8000_0708);
    check_eq("q_third_inst", bus.dec_inst_pyro, ins_c);
    tick();
    check_eq("q_drained", bus.dec_valid_pyro, 1'b0);

    // Reset while the branch is in EXEC
    bus.dec_retry_pyri = 1'b1;
    send("rbeq", 64'h8000_0800, enc_b(3'b000, 5'd1, 5'd2, 13'd16));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_bpv", bus.branch_pc_valid_pyro, 1'b0);
    check_eq("mrst_dec_valid", bus.dec_valid_pyro, 1'b0);
    check_eq("mrst_retry", bus.pc_retry_pyro, 1'b0);
    check_eq("mrst_rs1a", bus.rs1_addr_pyro, 5'd0);
    tick();
    check_eq("mrst_no_brsend", bus.branch_pc_valid_pyro, 1'b0);
    bus.dec_retry_pyri = 1'b0;
    send("post_rst", 64'h8000_0900, ins_a);
    check_eq("post_rst_dec_pc", bus.dec_pc_pyro, 64'h8000_0900);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
